// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: per-key two-flop synchroniser, hold-time debouncer and
// registered press/release strobes for active-low mechanical push-buttons.
// Every output comes straight from a flop; nothing combinational reaches the
// outputs from key_n.
module key_debounce_pulse #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic              any_pressed
);

    // Terminal count: a new value is accepted on the cycle the counter sits here.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] r_sync_p0;
    logic [N_KEYS-1:0] r_sync_p1;
    logic [CNT_W-1:0]  r_cnt [N_KEYS];
    logic [N_KEYS-1:0] r_level;
    logic [N_KEYS-1:0] r_press;
    logic [N_KEYS-1:0] r_release;
    logic              r_any;

    logic [N_KEYS-1:0] w_x;
    logic [N_KEYS-1:0] w_accept;
    logic [N_KEYS-1:0] w_level_nxt;

    // Two-flop synchroniser; reset value 1 means "released" on the active-low input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_p0 <= '1;
            r_sync_p1 <= '1;
        end else begin
            r_sync_p0 <= key_n;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Decide per key whether the synchronised value has been held long enough.
    always_comb begin
        w_x         = ~r_sync_p1;
        w_accept    = '0;
        w_level_nxt = r_level;
        for (int i = 0; i < N_KEYS; i++) begin
            if ((w_x[i] != r_level[i]) && (r_cnt[i] == LAST_CNT)) begin
                w_accept[i]    = 1'b1;
                w_level_nxt[i] = w_x[i];
            end
        end
    end

    // Hold counters: cleared whenever the input agrees with the accepted level
    // or a transition is accepted, so they never reach wrap-around.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_KEYS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (w_x[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Registered level, one-cycle strobes and the any-key flag updated together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_any     <= 1'b0;
        end else begin
            r_level   <= w_level_nxt;
            r_press   <= w_accept & w_x;
            r_release <= w_accept & ~w_x;
            r_any     <= |w_level_nxt;
        end
    end

    assign key_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign any_pressed   = r_any;

endmodule
